sort_frame_sequencer: RTL and testbench

- Controller that sequences the team's 8-entry one-cycle sorter.
- Collects an 8-element frame from an upstream valid/ready stream and loads it into the sorter by index, then pulses the sort command.
- Captures the packed sorted result after a fixed latency and streams it downstream one element per beat, largest first.
- Sits between the sample-stream producer and any consumer of sorted frames; owns all sorter control signals.

---
 rtl/sort_frame_sequencer_if.sv | 33 +++
 rtl/sort_frame_sequencer.sv | 124 ++++++++++++
 tb/tb_sort_frame_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_frame_sequencer_if.sv
// Stream-in, stream-out and sorter-control signals of the frame sequencer.
// master is the sequencer side; slave is the producer/sorter/consumer side.
interface sort_frame_sequencer_if #(
    parameter int BITWIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BITWIDTH-1:0]   in_data;
    logic                  in_last;

    logic                  srt_load;
    logic [2:0]            srt_idx;
    logic [BITWIDTH-1:0]   srt_din;
    logic                  srt_sortit;
    logic [8*BITWIDTH:0]   srt_dout;

    logic                  out_valid;
    logic                  out_ready;
    logic [BITWIDTH-1:0]   out_data;
    logic                  out_last;

    modport master (
        input  in_valid, in_data, in_last, srt_dout, out_ready,
        output in_ready, srt_load, srt_idx, srt_din, srt_sortit,
               out_valid, out_data, out_last
    );

    modport slave (
        output in_valid, in_data, in_last, srt_dout, out_ready,
        input  in_ready, srt_load, srt_idx, srt_din, srt_sortit,
               out_valid, out_data, out_last
    );
endinterface

// File: rtl/sort_frame_sequencer.sv
// Collects an 8-element frame, loads it into the 8-entry sorter, fires the sort,
// captures the result after SORT_LAT cycles and streams it out largest first.
module sort_frame_sequencer #(
    parameter int BITWIDTH = 8,
    parameter int SORT_LAT = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    sort_frame_sequencer_if.master bus,
    output logic                   busy,
    output logic                   err
);
    localparam logic [3:0] LAT = 4'(SORT_LAT);

    typedef enum logic [2:0] {FILL, PAD, SORT, WAIT, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              count;
    logic [2:0]              beat;
    logic [3:0]              lat_cnt;
    logic [8*BITWIDTH-1:0]   capture;
    logic                    lat_hit;

    logic                    in_ready;
    logic                    load;
    logic [2:0]              idx;
    logic [BITWIDTH-1:0]     din;
    logic                    sortit;
    logic                    out_valid;
    logic [BITWIDTH-1:0]     out_data;
    logic                    out_last;

    assign lat_hit = (lat_cnt + 4'd1) == LAT;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= FILL;
        else         state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default first so no branch can infer a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        load      = 1'b0;
        idx       = '0;
        din       = '0;
        sortit    = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    load = 1'b1;
                    idx  = count;
                    din  = bus.in_data;
                    if (count == 3'd7)    state_nxt = SORT;
                    else if (bus.in_last) state_nxt = PAD;
                end
            end
            PAD: begin
                load = 1'b1;
                idx  = count;
                if (count == 3'd7) state_nxt = SORT;
            end
            SORT: begin
                sortit    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (lat_hit) state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = capture[int'(beat)*BITWIDTH +: BITWIDTH];
                out_last  = (beat == 3'd7);
                if (bus.out_ready && beat == 3'd7) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    // Frame datapath; the capture register is cleared so a reset leaves no stale frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count   <= '0;
            beat    <= '0;
            lat_cnt <= '0;
            capture <= '0;
            err     <= 1'b0;
        end else begin
            if (load) count <= count + 3'd1;
            case (state)
                SORT: lat_cnt <= '0;
                WAIT: begin
                    lat_cnt <= lat_cnt + 4'd1;
                    if (lat_hit) begin
                        capture <= bus.srt_dout[8*BITWIDTH-1:0];
                        beat    <= '0;
                        if (!bus.srt_dout[8*BITWIDTH]) err <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        beat <= beat + 3'd1;
                        if (beat == 3'd7) count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.srt_load   = load;
    assign bus.srt_idx    = idx;
    assign bus.srt_din    = din;
    assign bus.srt_sortit = sortit;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_data;
    assign bus.out_last   = out_last;
    assign busy           = (state != FILL);
endmodule

// File: tb/tb_sort_frame_sequencer.sv
// Directed bench for sort_frame_sequencer with a behavioural one-cycle sorter.
// Expected sorted frames and load sequences are written out by hand.
module tb_sort_frame_sequencer;
    typedef logic [7:0] frame_t [8];

    logic clk;
    logic resetn;
    logic busy;
    logic err;

    sort_frame_sequencer_if #(.BITWIDTH(8)) bus ();

    sort_frame_sequencer #(.BITWIDTH(8), .SORT_LAT(1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural sorter: slot writes on load, sorted result plus done flag one cycle after sortit.
    logic [7:0] slot [8];
    logic       done_ok;

    function automatic logic [63:0] sort_pack();
        logic [7:0] v [8];
        logic [7:0] t;
        logic [63:0] r;
        for (int i = 0; i < 8; i++) v[i] = slot[i];
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7 - i; j++)
                if (v[j] < v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = v[k];
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.srt_load)   slot[bus.srt_idx] <= bus.srt_din;
        if (bus.srt_sortit) bus.srt_dout <= {done_ok, sort_pack()};
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    logic [10:0] loadq [$];
    logic [7:0]  outq  [$];
    logic        lastq [$];
    int          sort_cnt, stall_cnt, viol;
    logic        prev_stall, prev_sortit;
    logic [7:0]  prev_data;

    always @(negedge clk) begin
        if (resetn) begin
            if (bus.srt_load) loadq.push_back({bus.srt_idx, bus.srt_din});
            else if (bus.srt_idx != 3'd0 || bus.srt_din != 8'd0) viol++;
            if (bus.srt_load && bus.srt_sortit) viol++;
            if (bus.srt_sortit) begin
                sort_cnt++;
                if (prev_sortit) viol++;
            end
            if (busy && bus.in_ready) viol++;
            if (prev_stall && bus.out_data !== prev_data) viol++;
            if (bus.out_valid && !bus.out_ready) stall_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                outq.push_back(bus.out_data);
                lastq.push_back(bus.out_last);
            end
            prev_stall  = bus.out_valid && !bus.out_ready;
            prev_data   = bus.out_data;
            prev_sortit = bus.srt_sortit;
        end else begin
            prev_stall  = 1'b0;
            prev_sortit = 1'b0;
        end
    end

    // Downstream ready: always 1, or the 1,0,0,1 pattern in backpressure mode.
    logic bp_mode;
    int   bp_ph;
    logic bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        bus.out_ready = 1'b1;
        bp_ph = 0;
        forever begin
            @(posedge clk); #1;
            if (bp_mode) begin
                bus.out_ready = bp_pat[bp_ph];
                bp_ph = (bp_ph + 1) % 4;
            end else begin
                bus.out_ready = 1'b1;
                bp_ph = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        loadq.delete();
        outq.delete();
        lastq.delete();
        sort_cnt  = 0;
        stall_cnt = 0;
    endtask

    task automatic push(input logic [7:0] d, input logic last);
        logic acc;
        int   t;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            t++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'd0;
        check("push_accept", acc, 1);
    endtask

    task automatic send_full(input frame_t d, input logic last_on_8th);
        for (int i = 0; i < 8; i++) push(d[i], (i == 7) && last_on_8th);
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (outq.size() < n && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("out_count", outq.size(), n);
    endtask

    task automatic check_frame(input string tag, input frame_t exp);
        for (int i = 0; i < 8; i++) begin
            check({tag, "_data"}, (i < outq.size())  ? outq[i]  : 8'hxx, exp[i]);
            check({tag, "_last"}, (i < lastq.size()) ? lastq[i] : 1'bx, (i == 7));
        end
    endtask

    task automatic check_loads(input string tag, input frame_t exp);
        check({tag, "_nload"}, loadq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check({tag, "_idx"}, (i < loadq.size()) ? loadq[i][10:8] : 3'bx, i);
            check({tag, "_din"}, (i < loadq.size()) ? loadq[i][7:0]  : 8'hxx, exp[i]);
        end
    endtask

    initial begin
        resetn       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        bus.in_last  = 1'b0;
        done_ok      = 1'b1;
        bp_mode      = 1'b0;
        viol         = 0;
        prev_stall   = 1'b0;
        prev_sortit  = 1'b0;
        prev_data    = 8'd0;
        clear_logs();

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",      busy,           0);
        check("rst_err",       err,            0);
        check("rst_out_valid", bus.out_valid,  0);
        check("rst_out_last",  bus.out_last,   0);
        check("rst_out_data",  bus.out_data,   0);
        check("rst_load",      bus.srt_load,   0);
        check("rst_sortit",    bus.srt_sortit, 0);
        check("rst_in_ready",  bus.in_ready,   1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Full frame, last flag not used.
        clear_logs();
        send_full('{8'd3, 8'd9, 8'd1, 8'd7, 8'd0, 8'd255, 8'd4, 8'd4}, 1'b0);
        wait_out(8);
        check("full_busy_after",  busy,         0);
        check("full_ready_after", bus.in_ready, 1);
        check("full_sortcnt",     sort_cnt,     1);
        check_loads("full", '{8'd3, 8'd9, 8'd1, 8'd7, 8'd0, 8'd255, 8'd4, 8'd4});
        check_frame("full", '{8'd255, 8'd9, 8'd7, 8'd4, 8'd4, 8'd3, 8'd1, 8'd0});

        // Short frame: in_last on the second element pads slots 2..7 with zero.
        clear_logs();
        push(8'd5, 1'b0);
        push(8'd2, 1'b1);
        wait_out(8);
        check("short_sortcnt", sort_cnt, 1);
        check_loads("short", '{8'd5, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
        check_frame("short", '{8'd5, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});

        // One-element frame: seven pad loads.
        clear_logs();
        push(8'd42, 1'b1);
        wait_out(8);
        check_loads("single", '{8'd42, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
        check_frame("single", '{8'd42, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});

        // Backpressure during drain; in_last on the 8th beat must be ignored.
        clear_logs();
        bp_mode = 1'b1;
        send_full('{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80}, 1'b1);
        wait_out(8);
        bp_mode = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("bp_handshakes", outq.size(), 8);
        check("bp_stalled",    stall_cnt > 0, 1);
        check("bp_loads",      loadq.size(), 8);
        check_frame("bp", '{8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10});

        // Missing done flag sets sticky err, frame still drains.
        check("err_before", err, 0);
        clear_logs();
        done_ok = 1'b0;
        send_full('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 1'b0);
        wait_out(8);
        done_ok = 1'b1;
        check("err_set", err, 1);
        check_frame("nodone", '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});

        clear_logs();
        send_full('{8'd100, 8'd50, 8'd150, 8'd25, 8'd200, 8'd75, 8'd0, 8'd175}, 1'b0);
        wait_out(8);
        check("err_sticky", err, 1);
        check_frame("clean", '{8'd200, 8'd175, 8'd150, 8'd100, 8'd75, 8'd50, 8'd25, 8'd0});

        // Reset in the middle of a drain.
        clear_logs();
        send_full('{8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18}, 1'b0);
        wait_out(3);
        check("pre_rst_beat2", outq.size() > 2 ? outq[2] : 8'hxx, 16);
        resetn = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_err",       err,           0);
        check("mid_rst_busy",      busy,          0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_busy",     busy,         0);
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_no_output", outq.size(), 3);

        clear_logs();
        send_full('{8'd2, 8'd200, 8'd2, 8'd13, 8'd99, 8'd1, 8'd64, 8'd7}, 1'b0);
        wait_out(8);
        check_frame("after_rst", '{8'd200, 8'd99, 8'd64, 8'd13, 8'd7, 8'd2, 8'd2, 8'd1});

        // Upstream gap of three cycles between elements 4 and 5.
        clear_logs();
        push(8'd33, 1'b0);
        push(8'd44, 1'b0);
        push(8'd11, 1'b0);
        push(8'd22, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("gap_no_load", loadq.size(), 4);
        push(8'd66, 1'b0);
        push(8'd55, 1'b0);
        push(8'd88, 1'b0);
        push(8'd77, 1'b0);
        wait_out(8);
        check_loads("gap", '{8'd33, 8'd44, 8'd11, 8'd22, 8'd66, 8'd55, 8'd88, 8'd77});
        check_frame("gap", '{8'd88, 8'd77, 8'd66, 8'd55, 8'd44, 8'd33, 8'd22, 8'd11});

        check("protocol_violations", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
